// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg -- fetch/decode pipeline register with stall, flush and
//              fetch address-error (AdEL) tagging.
//
// Ports
//   clk        in   1   clock, rising edge
//   clr        in   1   synchronous active-high reset
//   stall      in   1   freeze the decode slot
//   flush      in   1   empty the decode slot (interrupt/exception)
//   instr_f    in  32   instruction word from fetch
//   pc8_f      in  32   fetch PC+8
//   br_d       in   1   instruction now in decode is a branch/jump
//   instr_d    out 32   registered instruction
//   pc8_d      out 32   registered PC+8
//   pc_d       out 32   pc8_d - 8 (combinational, wraps)
//   valid_d    out  1   decode slot holds a real fetched instruction
//   bd_d       out  1   held instruction is in a branch delay slot
//   exc_d      out  5   fetch exception code (0 none, 4 AdEL)
//   stall_cnt  out 32   saturating count of stalled cycles
//
// Build option
//   IF_ID_ADEL_EN : when defined, a fetch PC that is misaligned or outside
//                   0x00003000..0x00006FFC captures exc_d=4 and instr_d=0.
//                   Otherwise exc_d stays 0 and instr_f is taken as-is.
//
// State  | meaning
// RUN    | normal capture of the fetch stage every cycle
// HOLD   | slot frozen by stall, contents still a real instruction
// BUBBLE | slot emptied by flush; stays empty while stalled
// ---------------------------------------------------------------------------
module if_id_reg (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc8_f,
    input  logic        br_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc8_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic        bd_d,
    output logic [4:0]  exc_d,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, HOLD, BUBBLE} state_t;

    localparam logic [31:0] PC8_RESET = 32'h0000_3008;

    state_t      state;
    logic        valid_q;
    logic [4:0]  exc_f;
    logic [31:0] instr_cap;

`ifdef IF_ID_ADEL_EN
    logic [31:0] pc_f;
    logic        adel;

    always_comb begin
        pc_f      = pc8_f - 32'd8;
        adel      = (pc_f[1:0] != 2'b00) || (pc_f < 32'h0000_3000) ||
                    (pc_f > 32'h0000_6FFC);
        exc_f     = adel ? 5'd4 : 5'd0;
        instr_cap = adel ? 32'd0 : instr_f;
    end
`else
    always_comb begin
        exc_f     = 5'd0;
        instr_cap = instr_f;
    end
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= RUN;
            instr_d   <= 32'd0;
            pc8_d     <= PC8_RESET;
            valid_q   <= 1'b0;
            bd_d      <= 1'b0;
            exc_d     <= 5'd0;
            stall_cnt <= 32'd0;
        end else if (flush) begin
            // pc8_d still follows fetch so the restart address is visible
            state     <= BUBBLE;
            instr_d   <= 32'd0;
            pc8_d     <= pc8_f;
            valid_q   <= 1'b0;
            bd_d      <= 1'b0;
            exc_d     <= 5'd0;
        end else if (stall) begin
            state <= (state == BUBBLE) ? BUBBLE : HOLD;
            if (stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end else begin
            state   <= RUN;
            instr_d <= instr_cap;
            pc8_d   <= pc8_f;
            valid_q <= 1'b1;
            // a bubble is not a branch, whatever br_d says about it
            bd_d    <= br_d && (state != BUBBLE);
            exc_d   <= exc_f;
        end
    end

    assign valid_d = valid_q && (state != BUBBLE);
    assign pc_d    = pc8_d - 32'd8;

endmodule

// File: tb/tb_if_id_reg.sv
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        clr, stall, flush, br_d;
    logic [31:0] instr_f, pc8_f;
    logic [31:0] instr_d, pc8_d, pc_d, stall_cnt;
    logic        valid_d, bd_d;
    logic [4:0]  exc_d;

    if_id_reg dut (
        .clk       (clk),
        .clr       (clr),
        .stall     (stall),
        .flush     (flush),
        .instr_f   (instr_f),
        .pc8_f     (pc8_f),
        .br_d      (br_d),
        .instr_d   (instr_d),
        .pc8_d     (pc8_d),
        .pc_d      (pc_d),
        .valid_d   (valid_d),
        .bd_d      (bd_d),
        .exc_d     (exc_d),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model: what the decode slot should hold
    logic [31:0] m_instr, m_pc8, m_cnt;
    logic        m_valid, m_bd, m_empty;
    logic [4:0]  m_exc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit is_adel(input logic [31:0] pc8);
`ifdef IF_ID_ADEL_EN
        longint unsigned pc;
        pc = (longint'(pc8) + 64'h1_0000_0000 - 8) % 64'h1_0000_0000;
        return (pc % 4 != 0) || (pc < 'h3000) || (pc > 'h6FFC);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        if (clr) begin
            m_instr = 0; m_pc8 = 32'h3008; m_valid = 0; m_bd = 0;
            m_exc = 0; m_cnt = 0; m_empty = 0;
        end else if (flush) begin
            m_instr = 0; m_pc8 = pc8_f; m_valid = 0; m_bd = 0;
            m_exc = 0; m_empty = 1;
        end else if (stall) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else begin
            m_instr = is_adel(pc8_f) ? 32'd0 : instr_f;
            m_exc   = is_adel(pc8_f) ? 5'd4 : 5'd0;
            m_pc8   = pc8_f;
            m_valid = 1;
            m_bd    = br_d && !m_empty;
            m_empty = 0;
        end
    endtask

    task automatic compare_all();
        check("instr_d",   instr_d,   m_instr);
        check("pc8_d",     pc8_d,     m_pc8);
        check("pc_d",      pc_d,      m_pc8 - 32'd8);
        check("valid_d",   {31'd0, valid_d}, {31'd0, m_valid});
        check("bd_d",      {31'd0, bd_d},    {31'd0, m_bd});
        check("exc_d",     {27'd0, exc_d},   {27'd0, m_exc});
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic c, input logic s, input logic f, input logic b,
                         input logic [31:0] ins, input logic [31:0] pc8);
        clr = c; stall = s; flush = f; br_d = b; instr_f = ins; pc8_f = pc8;
    endtask

    initial begin
        drive(1, 0, 0, 0, 32'hDEAD_BEEF, 32'h1234_5678);
        m_instr = 0; m_pc8 = 0; m_valid = 0; m_bd = 0; m_exc = 0; m_cnt = 0; m_empty = 0;
        @(negedge clk);
        cycle();
        check("rst_instr", instr_d, 32'h0);
        check("rst_pc8",   pc8_d,   32'h3008);
        check("rst_pc",    pc_d,    32'h3000);
        check("rst_valid", {31'd0, valid_d}, 32'd0);
        check("rst_cnt",   stall_cnt, 32'd0);

        // plain capture
        drive(0, 0, 0, 0, 32'h3C01_0001, 32'h3008);
        cycle();
        check("cap_instr", instr_d, 32'h3C01_0001);
        check("cap_pc",    pc_d,    32'h3000);
        check("cap_valid", {31'd0, valid_d}, 32'd1);
        check("cap_exc",   {27'd0, exc_d},   32'd0);

        // three stalled cycles with fetch changing underneath
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, $urandom, 32'h3100 + 32'(i * 4));
            cycle();
        end
        check("stall_instr", instr_d,   32'h3C01_0001);
        check("stall_pc8",   pc8_d,     32'h3008);
        check("stall_cnt3",  stall_cnt, 32'd3);

        // flush beats stall, then a stall keeps the bubble
        drive(0, 1, 1, 1, 32'h1111_2222, 32'h3020);
        cycle();
        check("flush_instr", instr_d, 32'h0);
        check("flush_valid", {31'd0, valid_d}, 32'd0);
        check("flush_pc8",   pc8_d,   32'h3020);
        check("flush_cnt",   stall_cnt, 32'd3);
        drive(0, 1, 0, 1, 32'h3333_4444, 32'h3024);
        cycle();
        check("bubble_valid", {31'd0, valid_d}, 32'd0);
        check("bubble_cnt",   stall_cnt, 32'd4);

        // br_d seen while the slot is a bubble must not mark a delay slot
        drive(0, 0, 0, 1, 32'h1000_0003, 32'h300C);
        cycle();
        check("bubble_br", {31'd0, bd_d}, 32'd0);
        drive(0, 0, 0, 1, 32'h2400_0001, 32'h3010);
        cycle();
        check("ds_set", {31'd0, bd_d}, 32'd1);
        drive(0, 0, 0, 0, 32'h2400_0002, 32'h3014);
        cycle();
        check("ds_clr", {31'd0, bd_d}, 32'd0);

        // fetch address errors
        drive(0, 0, 0, 0, 32'hAAAA_5555, 32'h300A);
        cycle();
`ifdef IF_ID_ADEL_EN
        check("adel_mis_exc",   {27'd0, exc_d}, 32'd4);
        check("adel_mis_instr", instr_d, 32'h0);
`else
        check("adel_mis_exc",   {27'd0, exc_d}, 32'd0);
        check("adel_mis_instr", instr_d, 32'hAAAA_5555);
`endif
        drive(0, 0, 0, 0, 32'h5555_AAAA, 32'h7008);
        cycle();
`ifdef IF_ID_ADEL_EN
        check("adel_rng_exc", {27'd0, exc_d}, 32'd4);
`else
        check("adel_rng_exc", {27'd0, exc_d}, 32'd0);
`endif

        // reset in the middle of a stall
        drive(0, 1, 0, 0, 32'h0, 32'h3040);
        cycle();
        drive(1, 1, 0, 1, 32'h7777_7777, 32'h3050);
        cycle();
        check("rst_stall_cnt",   stall_cnt, 32'd0);
        check("rst_stall_pc8",   pc8_d,     32'h3008);
        check("rst_stall_instr", instr_d,   32'h0);
        check("rst_stall_valid", {31'd0, valid_d}, 32'd0);
        check("rst_stall_bd",    {31'd0, bd_d},    32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            if ($urandom_range(0, 3) == 0) pc = $urandom;
            else pc = 32'h3000 + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3,
                  $urandom, pc);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port clr, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port stall, input, 1, hazard-unit freeze of the decode stage.
REQ-004 SHALL have port flush, input, 1, interrupt/exception request; empties the decode stage.
REQ-005 SHALL have port instr_f, input, 32, instruction word from the fetch stage.
REQ-006 SHALL have port pc8_f, input, 32, fetch-stage PC+8.
REQ-007 SHALL have port br_d, input, 1, high when the instruction currently held in decode is a branch or jump.
REQ-008 SHALL have port instr_d, output, 32, registered instruction.
REQ-009 SHALL have port pc8_d, output, 32, registered PC+8.
REQ-010 SHALL have port pc_d, output, 32, combinational pc8_d minus 8.
REQ-011 SHALL have port valid_d, output, 1, the decode slot holds a real fetched instruction.
REQ-012 SHALL have port bd_d, output, 1, the held instruction sits in a branch delay slot.
REQ-013 SHALL have port exc_d, output, 5, fetch exception code; 0 = none, 4 = AdEL.
REQ-014 SHALL have port stall_cnt, output, 32, count of stalled cycles.

Function
REQ-015 SHALL apply update priority each edge: clr > flush > stall > capture.
REQ-016 SHALL, on capture, load instr_d=instr_f, pc8_d=pc8_f, valid_d=1, bd_d=br_d, exc_d=computed code; latency one cycle.
REQ-017 SHALL, on stall without flush, hold all of instr_d, pc8_d, valid_d, bd_d and exc_d unchanged.
REQ-018 SHALL, on flush (regardless of stall), load instr_d=0, valid_d=0, bd_d=0, exc_d=0 and pc8_d=pc8_f.
REQ-019 SHALL maintain a state machine with states RUN, HOLD and BUBBLE.
REQ-020 SHALL transition the state machine as follows: clr->RUN; flush->BUBBLE; stall->HOLD from RUN or HOLD, while BUBBLE stays BUBBLE under stall; otherwise->RUN.
REQ-021 SHALL force valid_d=0 in state BUBBLE.
REQ-022 SHALL set bd_d only on capture, and never set it from a br_d sampled while in BUBBLE.
REQ-023 SHALL increment stall_cnt by 1 on each edge with stall=1 and flush=0 and clr=0, saturating at 0xFFFFFFFF.
REQ-024 SHALL compute pc_d with 32-bit wrap-around and without a register.

Reset
REQ-025 SHALL, on clr, load instr_d=0, pc8_d=0x00003008, valid_d=0, bd_d=0, exc_d=0, stall_cnt=0 and state=RUN.
REQ-026 SHALL let a clr asserted together with stall or flush win, with identical result to clr alone.

Configuration
REQ-027 SHALL, with IF_ID_ADEL_EN defined, compute exc_d=4 when pc8_f-8 is misaligned (bits 1:0 non-zero) or outside 0x00003000..0x00006FFC, and capture instr_d=0 in that case.
REQ-028 SHALL, without IF_ID_ADEL_EN, tie exc_d to 0 and capture instr_f unmodified.

Verification
REQ-029 SHALL cover plain capture: instr_f=0x3C010001, pc8_f=0x3008 -> next cycle instr_d=0x3C010001, pc_d=0x3000, valid_d=1, exc_d=0.
REQ-030 SHALL cover stall: 3 cycles of stall with changing instr_f -> outputs frozen and stall_cnt=3.
REQ-031 SHALL cover flush and stall together: instr_d=0, valid_d=0, pc8_d=pc8_f and stall_cnt unchanged; a following stall cycle keeps valid_d=0.
REQ-032 SHALL cover the delay slot: br_d=1 then capture of pc8_f=0x3010 -> bd_d=1; the next capture with br_d=0 -> bd_d=0.
REQ-033 SHALL cover AdEL with IF_ID_ADEL_EN defined: pc8_f=0x300A gives exc_d=4, instr_d=0, and pc8_f=0x7008 gives exc_d=4; without the macro both give exc_d=0.
REQ-034 SHALL cover reset mid-stall: clr with stall=1 -> all reset values, including stall_cnt=0 and pc8_d=0x3008.
